// File: rtl/seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// seq_mult_ctrl
//   Sequencing controller for a WIDTH x WIDTH unsigned shift-and-add multiply.
//   One WIDTH-bit ripple-carry adder (carry-in tied 0, carry-out kept) is
//   reused for WIDTH iterations. Operands enter and the product leaves
//   through valid/ready handshakes.
//
// Ports
//   clk           in   1        rising-edge clock
//   reset_n       in   1        asynchronous active-low reset
//   in_valid      in   1        operand pair valid
//   in_ready      out  1        operands accepted (high only in IDLE)
//   multiplicand  in   WIDTH    unsigned operand M
//   multiplier    in   WIDTH    unsigned operand Q
//   out_valid     out  1        product valid (high only in DONE)
//   out_ready     in   1        consumer accepts product
//   product       out  2*WIDTH  unsigned M*Q, held until the next product
//   busy          out  1        high while iterating (RUN)
// ---------------------------------------------------------------------------
module seq_mult_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   add_s;
    logic               add_co;
    logic               last_iter;

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Shared ripple-carry adder: a = A, b = M, carry-in tied low.
    always_comb begin : adder
        logic carry;
        carry = 1'b0;
        add_s = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            add_s[i] = a_q[i] ^ m_q[i] ^ carry;
            carry    = (a_q[i] & m_q[i]) | (carry & (a_q[i] ^ m_q[i]));
        end
        add_co = carry;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == RUN);
        out_valid = (state_q == DONE);
        product   = product_q;
    end

    // Datapath next values
    always_comb begin
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d   = multiplicand;
                    q_d   = multiplier;
                    a_d   = '0;
                    c_d   = 1'b0;
                    cnt_d = '0;
                end
            end
            RUN: begin
                // {C,A,Q} shifted right by one; on an add step the adder
                // carry-out becomes the new A MSB so no product bit is lost.
                // C is always refilled with 0.
                if (q_q[0]) begin
                    a_d = {add_co, add_s[WIDTH-1:1]};
                    q_d = {add_s[0], q_q[WIDTH-1:1]};
                end else begin
                    a_d = {c_q, a_q[WIDTH-1:1]};
                    q_d = {a_q[0], q_q[WIDTH-1:1]};
                end
                c_d   = 1'b0;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    cnt_d     = '0;
                    product_d = {a_d, q_d};
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_mult_ctrl
//   Self-checking bench for seq_mult_ctrl. Expected products come from plain
//   integer multiplication; timing expectations come from the documented
//   handshake latency (WIDTH RUN cycles, WIDTH+2 cycles per product).
// ---------------------------------------------------------------------------
module tb_seq_mult_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] multiplicand = '0;
    logic [WIDTH-1:0] multiplier = '0;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [2*WIDTH-1:0] product;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_mult_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction starting from IDLE. Optionally stalls in DONE and
    // optionally pulses in_valid (M=1,Q=1) during RUN, which must be ignored.
    task automatic run_op(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q,
                          input int stall, input bit pulse_mid);
        int lat;
        int busy_cnt;
        int exp_p;
        exp_p = int'(m) * int'(q);
        check("in_ready_idle", in_ready, 1);
        multiplicand = m;
        multiplier   = q;
        in_valid     = 1'b1;
        out_ready    = 1'b0;
        tick();
        in_valid     = 1'b0;
        multiplicand = WIDTH'($urandom);
        multiplier   = WIDTH'($urandom);
        lat = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 20) begin
            if (busy) busy_cnt++;
            if (pulse_mid && lat == 1) begin
                in_valid     = 1'b1;
                multiplicand = 1;
                multiplier   = 1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, WIDTH);
        check("busy_cycles", busy_cnt, WIDTH);
        check("product", product, exp_p);
        for (int i = 0; i < stall; i++) begin
            in_valid     = 1'b1;
            multiplicand = WIDTH'($urandom);
            multiplier   = WIDTH'($urandom);
            tick();
            check("stall_out_valid", out_valid, 1);
            check("stall_product", product, exp_p);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_product_held", product, exp_p);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int exp_q[$];
        int idx;
        int got;
        int last;
        int cyc;
        int w;

        // Reset state
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_product", product, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Directed operand cases
        run_op(4'hF, 4'hF, 0, 1'b0);
        run_op(4'h9, 4'h6, 0, 1'b0);
        run_op(4'h0, 4'hB, 0, 1'b0);
        run_op(4'h7, 4'h1, 0, 1'b0);
        // Stall in DONE with in_valid asserted
        run_op(4'hC, 4'hD, 3, 1'b0);
        // in_valid pulse during RUN is ignored
        run_op(4'h5, 4'hA, 0, 1'b1);

        // Reset in the second RUN cycle
        multiplicand = 4'hE;
        multiplier   = 4'hB;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_product", product, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        run_op(4'h3, 4'h5, 0, 1'b0);

        // Reset while holding a product in DONE
        multiplicand = 4'hD;
        multiplier   = 4'h9;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            tick();
            w++;
        end
        check("done_reached", out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("done_rst_out_valid", out_valid, 0);
        check("done_rst_product", product, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Randomized transactions
        for (int n = 0; n < 20; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        end

        // Exhaustive back-to-back with in_valid/out_ready held high
        out_ready = 1'b1;
        idx  = 0;
        got  = 0;
        last = -1;
        cyc  = 0;
        while (got < 256 && cyc < 256 * 6 + 50) begin
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    check("exh_product", product, exp_q.pop_front());
                end else begin
                    check("exh_unexpected_result", 1, 0);
                end
                if (last >= 0) check("exh_interval", cyc - last, WIDTH + 2);
                last = cyc;
                got++;
            end
            if (in_ready) begin
                if (idx < 256) begin
                    multiplicand = WIDTH'(idx >> 4);
                    multiplier   = WIDTH'(idx & 15);
                    in_valid     = 1'b1;
                    exp_q.push_back((idx >> 4) * (idx & 15));
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("exh_count", got, 256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
